// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_arbiter: FSM state encoding, transaction owner
// encoding and default bus widths.
package mem_arb_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  // Arbiter FSM states, kept as plain constants for compatibility with
  // existing code that compares against raw encodings.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  // Which CPU port owns the transaction currently in flight.
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares a single-port unified memory between the instruction-fetch port and
// the data (MEM-stage) port. One transaction is in flight at a time and the
// data port has priority. Each transaction walks IDLE -> REQ -> WAIT -> RESP,
// and the owner's done pulse is issued in RESP.
//
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_MAX consecutive
// data grants that left a pending fetch waiting, the next arbitration in
// which both ports request goes to fetch.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // Instruction-fetch port
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_done,
  output logic            i_stall,
  // Data port
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_done,
  output logic            d_stall,
  // Memory side
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  // Reject configurations that cannot work before they reach simulation.
  if ((DW % 8) != 0 || STARVE_MAX < 1) begin : gBadParams
    $error("mem_arbiter: DW must be a multiple of 8 and STARVE_MAX at least 1");
  end

  state_t state;
  logic   owner;
  logic   grantI;
  logic   grantD;
  logic   forceI;

  // Stalls freeze the F/M stages for every cycle a port waits, including the
  // request cycle itself, and release in the done cycle.
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starveCnt;

  assign forceI = (starveCnt == STARVE_LIM);

  // Count data grants that overtook a waiting fetch; any fetch grant clears
  // the count, so it saturates naturally at STARVE_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (grantI) begin
      starveCnt <= '0;
    end else if (grantD && i_req) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end
`else
  assign forceI = 1'b0;
`endif

  // Arbitration happens only in IDLE: data wins unless the fetch side has
  // been starved long enough to be forced through.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == ST_IDLE) begin
      grantI = i_req & (~d_req | forceI);
      grantD = d_req & ~grantI;
    end
  end

  // Transaction FSM: latch the winner's request into the mem_* registers,
  // hold mem_req until accepted, capture the response, pulse done.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    if (rst) begin
      // NOTE: reset is synchronous; it aborts any transaction and discards a
      // response still in flight, since IDLE ignores mem_rvalid.
      state     <= ST_IDLE;
      owner     <= OWN_I;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grantD) begin
            owner     <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_we ? d_be : {(DW/8){1'b1}};
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state     <= ST_REQ;
          end else if (grantI) begin
            owner     <= OWN_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_be    <= {(DW/8){1'b1}};
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            // Write acks complete the transaction without touching rdata.
            if (!mem_we) begin
              if (owner == OWN_D) d_rdata <= mem_rdata;
              else                i_rdata <= mem_rdata;
            end
            if (owner == OWN_D) d_done <= 1'b1;
            else                i_done <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions with
// hand-computed latencies and data, plus hand-written sequences for
// collision, reset during WAIT, spurious rvalid and the starvation guard.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_done;
  logic          i_stall;
  logic          d_req;
  logic          d_we;
  logic [BW-1:0] d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic          d_stall;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  bit rvPend;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_done    (i_done),
    .i_stall   (i_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_done    (d_done),
    .d_stall   (d_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            isD;
    bit            we;
    logic [BW-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] memData;
    int            gntDly;
    int            rvDly;
    int            expLat;
    logic [BW-1:0] expBe;
    logic [DW-1:0] expRdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: accept immediately, respond the cycle after the accept.
  task automatic respond();
    mem_gnt    = mem_req;
    mem_rvalid = rvPend;
    mem_rdata  = mem_addr ^ 32'h5A5A_0000;
    rvPend     = mem_req;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_mem_req"},   mem_req,   0);
    check({tag, "_mem_we"},    mem_we,    0);
    check({tag, "_mem_be"},    mem_be,    0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_i_rdata"},   i_rdata,   0);
    check({tag, "_d_rdata"},   d_rdata,   0);
    check({tag, "_i_done"},    i_done,    0);
    check({tag, "_d_done"},    d_done,    0);
  endtask

  // One isolated transaction with programmable gnt/rvalid delays.
  task automatic runTxn(input int idx, input vec_t v);
    int    doneCyc   = -1;
    int    reqSeen   = 0;
    int    waitCnt   = 0;
    bit    granted   = 1'b0;
    bit    responded = 1'b0;
    string tag       = $sformatf("vec%0d", idx);
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (v.isD) begin
      d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    #1;
    check({tag, "_stall_c0"}, v.isD ? d_stall : i_stall, 1);
    check({tag, "_mem_req_c0"}, mem_req, 0);
    for (int c = 1; c <= 40 && doneCyc < 0; c++) begin
      tick();
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'hFFFF_FFFF;
      if (mem_req && !granted) begin
        check({tag, "_mem_addr"}, mem_addr, v.addr);
        check({tag, "_mem_we"},   mem_we,   v.we);
        check({tag, "_mem_be"},   mem_be,   v.expBe);
        if (v.isD && v.we) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
        if (reqSeen == v.gntDly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        reqSeen++;
      end else if (granted && !responded) begin
        if (waitCnt == v.rvDly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.memData;
          responded  = 1'b1;
        end
        waitCnt++;
      end
      #1;
      if (i_done || d_done) begin
        doneCyc = c;
        check({tag, "_latency"},    doneCyc, v.expLat);
        check({tag, "_req_cycles"}, reqSeen, v.gntDly + 1);
        check({tag, "_owner_done"}, v.isD ? d_done : i_done, 1);
        check({tag, "_other_done"}, v.isD ? i_done : d_done, 0);
        check({tag, "_rdata"},      v.isD ? d_rdata : i_rdata, v.expRdata);
        check({tag, "_stall_done"}, v.isD ? d_stall : i_stall, 0);
      end else begin
        check({tag, "_stall_wait"}, v.isD ? d_stall : i_stall, 1);
      end
    end
    if (doneCyc < 0) check({tag, "_timeout"}, 0, 1);
    tick();
    i_req = 1'b0;
    d_req = 1'b0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    check({tag, "_done_pulse"}, {i_done, d_done}, 0);
    check({tag, "_bubble"}, mem_req, 0);
  endtask

  initial begin : main
    int dDone;
    int iDone;
    int nGrant;
    bit prevReq;
    bit iDoneSeen;
    logic [AW-1:0] expAddr[5];

    //        isD we  be     addr        wdata         memData       gnt rv lat expBe  expRdata
    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0100, 32'h0, 32'h0050_0093, 0, 0, 3, 4'hF, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 4'h5, 32'h0000_2000, 32'h0, 32'h1122_3344, 0, 0, 3, 4'hF, 32'h1122_3344};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0040, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 2, 0, 5, 4'h3, 32'h1122_3344};
    vecs[3] = '{1'b0, 1'b0, 4'h0, 32'h0000_0104, 32'h0, 32'h00A0_0113, 1, 2, 6, 4'hF, 32'h00A0_0113};
    vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 0, 3, 6, 4'hF, 32'hCAFE_F00D};
    vecs[5] = '{1'b1, 1'b1, 4'hC, 32'h0000_0044, 32'h1234_5678, 32'h0, 1, 1, 5, 4'hC, 32'hCAFE_F00D};

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rvPend = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst = 1'b0;

    // Single transactions from the table.
    for (int i = 0; i < 6; i++) runTxn(i, vecs[i]);

    // Collision: both ports request in the same cycle, data goes first.
    rvPend = 1'b0;
    dDone = -1;
    iDone = -1;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
    i_req = 1'b1; i_addr = 32'h108;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("coll_i_stall_c0", i_stall, 1);
    for (int c = 1; c <= 15 && iDone < 0; c++) begin
      tick();
      if (dDone >= 0 && c == dDone + 1) d_req = 1'b0;
      respond();
      #1;
      if (c == 1) begin
        check("coll_c1_mem_req",  mem_req,  1);
        check("coll_c1_mem_addr", mem_addr, 32'h2000);
      end
      if (c == 5) begin
        check("coll_c5_mem_req",  mem_req,  1);
        check("coll_c5_mem_addr", mem_addr, 32'h108);
      end
      check("coll_one_done", {i_done, d_done} == 2'b11, 0);
      if (d_done && dDone < 0) dDone = c;
      if (i_done) iDone = c;
      else check("coll_i_stall", i_stall, 1);
    end
    check("coll_d_done_cycle", dDone, 3);
    check("coll_i_done_cycle", iDone, 7);
    check("coll_d_rdata", d_rdata, 32'h5A5A_2000);
    check("coll_i_rdata", i_rdata, 32'h5A5A_0108);
    tick();
    i_req = 1'b0;
    respond();
    #1;
    check("coll_end_mem_req", mem_req, 0);

    // Reset while the data read sits in WAIT, then a late rvalid.
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h5000;
    tick();
    check("rstw_c1_mem_req", mem_req, 1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("rstw_c2_wait", mem_req, 0);
    tick();
    rst = 1'b0;
    d_req = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    #1;
    checkResetOutputs("rstw_after");
    for (int c = 0; c < 3; c++) begin
      tick();
      mem_rvalid = 1'b0;
      #1;
      check("rstw_no_done", {i_done, d_done}, 0);
      check("rstw_d_rdata", d_rdata, 0);
      check("rstw_mem_req", mem_req, 0);
    end

    // Spurious rvalid while idle must do nothing.
    for (int c = 0; c < 3; c++) begin
      tick();
      mem_rvalid = 1'b1;
      mem_rdata = 32'h7777_7777;
      #1;
      check("spur_no_done", {i_done, d_done}, 0);
      check("spur_mem_req", mem_req, 0);
      check("spur_rdata", {i_rdata, d_rdata}, 0);
    end
    tick();
    mem_rvalid = 1'b0;

    // Data request held continuously against a waiting fetch.
`ifdef MEM_ARB_STARVE_GUARD_EN
    expAddr = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h200};
`else
    expAddr = '{32'h4000, 32'h4000, 32'h4000, 32'h4000, 32'h4000};
`endif
    rvPend = 1'b0;
    nGrant = 0;
    prevReq = 1'b0;
    iDoneSeen = 1'b0;
    tick();
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000;
    i_req = 1'b1; i_addr = 32'h200;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 1; c <= 60 && nGrant < 5; c++) begin
      tick();
      if (iDoneSeen) i_req = 1'b0;
      respond();
      #1;
      if (mem_req && !prevReq) begin
        check($sformatf("starve_grant%0d", nGrant), mem_addr, expAddr[nGrant]);
        nGrant++;
      end
      prevReq = mem_req;
      iDoneSeen = i_done;
    end
    check("starve_grant_count", nGrant, 5);
    d_req = 1'b0;
    i_req = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      respond();
    end
    #1;
    check("starve_drained", mem_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and data (MEM-stage) port.
- Sits between the CPU core's fetch/data interfaces and the memory.
- Serialises requests, one outstanding transaction at a time; data side has priority.
- Returns per-port done pulses, read data and stall signals, so the hazard logic can freeze the F/M stages while a port waits.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- STARVE_MAX, 4, consecutive lost arbitrations before fetch is force-granted (only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  AW  fetch address; stable while i_req.
- i_rdata  out  DW  fetched instruction; valid while i_done.
- i_done  out  1  one-cycle fetch completion pulse.
- i_stall  out  1  i_req & ~i_done (combinational).
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  DW/8  byte enables for writes.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_rdata  out  DW  load data; valid while d_done.
- d_done  out  1  one-cycle data completion pulse.
- d_stall  out  1  d_req & ~d_done (combinational).
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  write.
- mem_be  out  DW/8  byte enables (all ones for fetch and reads).
- mem_addr  out  AW  address.
- mem_wdata  out  DW  write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  response (read data or write ack); earliest the cycle after mem_gnt.
- mem_rdata  in  DW  read data.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; mem_req, mem_we, i_done, d_done = 0; mem_addr, mem_wdata, mem_be, i_rdata, d_rdata = 0; grant owner cleared.
- FSM has four states:
  - IDLE: if d_req, grant D; else if i_req, grant I; else stay. On grant, latch addr/we/be/wdata into the mem_* registers, set mem_req=1, go to REQ.
  - REQ: mem_req=1. On mem_gnt, clear mem_req next cycle and go to WAIT.
  - WAIT: on mem_rvalid, register mem_rdata into the owner's rdata (reads only; write leaves rdata unchanged) and go to RESP.
  - RESP: owner's done=1 for exactly this cycle, then IDLE.
- Both reqs high in IDLE: D wins; I waits.
- Minimum latency, request sampled at cycle 0:
  - mem_req at cycle 1.
  - gnt at cycle 1, rvalid at cycle 2, done at cycle 3.
- Each extra gnt or rvalid wait cycle adds one cycle.
- RESP→IDLE costs one bubble; a request still high in IDLE after done is treated as a new request. The requester must update or drop req in the cycle after done.
- Once granted, request inputs are not re-sampled; requester changes or drops of req are ignored and the transaction still completes with done.
- mem_rvalid in IDLE/REQ/RESP is ignored (no state change, no done).
- Reset in any state aborts immediately to IDLE; a late mem_rvalid from an aborted access is ignored.
- Never both i_done and d_done in the same cycle; never more than one outstanding mem transaction.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - A $clog2(STARVE_MAX+1)-bit counter increments each time IDLE grants D while i_req=1.
  - Resets to 0 when I is granted.
  - When the counter equals STARVE_MAX and both request, I is granted.
- Undefined: strict D priority, no counter.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, REQ, WAIT, RESP).
  - owner encoding (OWN_I=0, OWN_D=1).
  - default AW/DW constants.
- Single module; starvation counter inline, no sub-module warranted.

Test Plan:
- Lone fetch:
  - Stimulus: i_req=1, i_addr=0x100, memory gnt immediate, rvalid next cycle with 0x00500093.
  - Response: mem_addr=0x100 at cycle 1; i_done with i_rdata=0x00500093 at cycle 3; i_stall high cycles 0-2.
- Collision:
  - Stimulus: i_req and d_req (read 0x2000) both rise at cycle 0.
  - Response: D served first (d_done cycle 3); I granted at cycle 4, i_done cycle 7.
- Write:
  - Stimulus: d_we=1, d_be=4'b0011, addr 0x40, wdata 0xDEADBEEF, gnt delayed 2 cycles.
  - Response: mem_req held 3 cycles with stable fields; d_done after ack; d_rdata unchanged.
- Reset mid-WAIT:
  - Stimulus: rst during WAIT, then mem_rvalid one cycle later.
  - Response: all outputs at reset values; no done pulse.
- Spurious rvalid:
  - Stimulus: mem_rvalid=1 in IDLE.
  - Response: no state change, no done.
- Starvation guard (macro on, STARVE_MAX=4):
  - Stimulus: d_req held continuously with i_req=1.
  - Response: 4 D grants, then the 5th grant goes to I.
